uart_tx_frame: RTL and testbench

UART transmit framer, the transmit-side counterpart of the RX start/parity/stop checkers. It accepts a parallel word with a single-cycle valid strobe and serialises it LSB-first as a UART frame on TX_OUT: one start bit, DATA_WIDTH data bits, an optional even/odd parity bit, and one stop bit. CLK is the TX bit clock, already divided to the baud rate by the clock divider, so one CLK cycle equals one bit period. Busy is returned to the upstream FIFO/controller for flow control.

---
 rtl/uart_tx_frame.sv | 128 ++++++++++++
 tb/tb_uart_tx_frame.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional even/odd parity, stop bit.
// CLK runs at the bit rate; TX_OUT and Busy are registered from the state being entered.
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// START  | start bit (low) on the line
// DATA   | data bit idx_q on the line
// PARITY | parity bit on the line
// STOP   | stop bit (high) on the line
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptyp_q, ptyp_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (DATA_VALID) begin
          data_d  = P_DATA;
          pen_d   = PAR_EN;
          ptyp_d  = PAR_TYP;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (pen_q) begin
            state_d = PARITY;
            tx_d    = (^data_q) ^ ptyp_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          idx_d = idx_q + CNT_WIDTH'(1);
          tx_d  = data_q[idx_d];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end
      STOP: begin
        // Always one idle cycle after the stop bit before the next acceptance.
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected line bits are queued when a
// frame is requested and popped one per bit period while the frame is on the line.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_frame(input logic [7:0] d, input logic pen, input logic pt);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back((^d) ^ pt);
    exp_q.push_back(1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #1 RST = 1'b0;
    #2;
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: tx=%b busy=%b required tx=1 busy=0", i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_single_frame(input string name, input logic [7:0] d,
                                   input logic pen, input logic pt);
    int len;
    logic e;
    len = 2 + 8 + (pen ? 1 : 0);
    P_DATA = d; PAR_EN = pen; PAR_TYP = pt; DATA_VALID = 1'b1;
    push_frame(d, pen, pt);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    for (int i = 0; i < len; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (TX_OUT !== e || Busy !== 1'b1) begin
        failures++;
        $display("FAIL %s bit%0d: tx=%b busy=%b required tx=%b busy=1", name, i, TX_OUT, Busy, e);
      end
      @(negedge CLK);
    end
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end: tx=%b busy=%b required tx=1 busy=0", name, TX_OUT, Busy);
    end
  endtask

  task automatic test_mid_frame_disturb();
    logic e;
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    push_frame(8'h3C, 1'b1, 1'b0);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (TX_OUT !== e || Busy !== 1'b1) begin
        failures++;
        $display("FAIL disturb bit%0d: tx=%b busy=%b required tx=%b busy=1", i, TX_OUT, Busy, e);
      end
      if (i == 4) begin
        DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_TYP = ~PAR_TYP;
      end else if (i == 5) begin
        DATA_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL disturb_idle[%0d]: tx=%b busy=%b required tx=1 busy=0", i, TX_OUT, Busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    logic e;
    vals[0] = 8'h55; vals[1] = 8'hAA; vals[2] = 8'h0F;
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    P_DATA = vals[0]; DATA_VALID = 1'b1;
    push_frame(vals[0], 1'b1, 1'b0);
    @(negedge CLK);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 11; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (TX_OUT !== e || Busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b f%0d bit%0d: tx=%b busy=%b required tx=%b busy=1", f, i, TX_OUT, Busy, e);
        end
        if (i == 10 && f < 2) begin
          P_DATA = vals[f+1];
          push_frame(vals[f+1], 1'b1, 1'b0);
        end
        @(negedge CLK);
      end
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b gap f%0d: tx=%b busy=%b required tx=1 busy=0", f, TX_OUT, Busy);
      end
      if (f == 2) DATA_VALID = 1'b0;
      @(negedge CLK);
    end
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b after: tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic e;
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    push_frame(8'h96, 1'b1, 1'b1);
    @(negedge CLK);
    DATA_VALID = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (TX_OUT !== e || Busy !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid bit%0d: tx=%b busy=%b required tx=%b busy=1", i, TX_OUT, Busy, e);
      end
      if (i < 6) @(negedge CLK);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async: tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
    end
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid idle[%0d]: tx=%b busy=%b required tx=1 busy=0", i, TX_OUT, Busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame("a5_even", 8'hA5, 1'b1, 1'b0);
    test_single_frame("00_odd", 8'h00, 1'b1, 1'b1);
    test_single_frame("ff_nopar", 8'hFF, 1'b0, 1'b0);
    test_single_frame("5a_odd", 8'h5A, 1'b1, 1'b1);
    test_mid_frame_disturb();
    test_back_to_back();
    test_reset_mid_frame();
    test_single_frame("after_rst", 8'hC3, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
